cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
- Multicycle state sequencer for the MIPS core; generates the `state_t` value consumed by the control decoder (FETCH → EXEC1 → EXEC2 → FETCH).
- Stalls on memory waitrequest and detects the halt condition (next fetch address = 0).
- Reports CPU activity and a retired-instruction count.
- Sits between the bus interface/PC unit and the control decoder.

Parameters:
- COUNT_W, 32: width of retired-instruction counter.
- STALL_TIMEOUT, 1024: max consecutive stall cycles before fault (only with the optional feature).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- waitrequest_i  input  1  memory bus not ready; current access must be held.
- ram_read_en_i  input  1  read requested this cycle (from control decoder).
- ram_write_en_i  input  1  write requested this cycle (from control decoder).
- pc_next_i  input  32  address of next instruction fetch, valid in EXEC2 (from PC unit, delay slot already resolved).
- state_o  output  state_t  current state; FETCH=2'd0, EXEC1=2'd1, EXEC2=2'd2, HALT=2'd3 (HALT added to the codes package).
- stall_o  output  1  current state is held this cycle; downstream gates pc/regfile/ir write enables with !stall_o.
- active_o  output  1  CPU running (state != HALT).
- halt_o  output  1  single-cycle pulse on the cycle HALT is entered.
- fault_o  output  1  sticky stall-timeout fault.
- instr_count_o  output  COUNT_W  number of retired instructions.

Behaviour:
- Reset (synchronous, any state, including mid-stall): on the next edge, state_o=FETCH, stall_o=0, active_o=1, halt_o=0, fault_o=0, instr_count_o=0. A stall in progress is abandoned; no retire is counted that cycle.
- mem_busy = (ram_read_en_i | ram_write_en_i) & waitrequest_i.
- stall_o = mem_busy & (state_o != HALT). It is combinational, same cycle.

State transitions, evaluated each edge:
- FETCH: mem_busy → FETCH; else → EXEC1.
- EXEC1: mem_busy → EXEC1; else → EXEC2.
- EXEC2: mem_busy → EXEC2. Else the instruction retires: instr_count_o += 1, then:
  - pc_next_i == 32'h0 → HALT, halt_o=1 for one cycle.
  - otherwise → FETCH.
- HALT: stays until reset. Memory requests and waitrequest_i are ignored. stall_o=0, active_o=0.

Further rules:
- Latency: 3 cycles per instruction with no stalls. Each stalled cycle adds exactly 1 cycle.
- waitrequest_i with no read/write enable does not stall.
- Retire counter saturates at all-ones. No wrap.
- Halting instruction: it is counted, then HALT is entered on the same edge.
- active_o is registered. It falls on the same edge state_o becomes HALT.

Optional Feature:
- Macro: CPU_SEQ_STALL_TIMEOUT_EN.
- With the macro: a stall counter increments on each cycle stall_o=1 and clears on any non-stalled cycle. When it reaches STALL_TIMEOUT:
  - next state is HALT;
  - fault_o is set (sticky until reset);
  - halt_o pulses;
  - no retire is counted.
- Without the macro: stalls last indefinitely and fault_o is tied 0. No counter logic is present.

Test Plan:
- Reset, then waitrequest_i=0 and pc_next_i=32'hBFC00004 for 9 cycles → states 0,1,2 repeated 3 times; instr_count_o=3; stall_o never 1.
- In FETCH, ram_read_en_i=1 with waitrequest_i=1 for 4 cycles → state_o holds 0 and stall_o=1 for 4 cycles, then EXEC1 on the 5th edge. A 3-stall write in EXEC2 gives instruction latency 6 and a single count increment.
- EXEC2 with pc_next_i=32'h0 and no stall → next cycle state_o=3, halt_o=1 for exactly 1 cycle, active_o=0, count incremented. Then waitrequest_i and enables toggled for 10 cycles → no change.
- Assert reset while in EXEC1 during a stall → next edge state_o=0, instr_count_o=0, stall_o=0, active_o=1.
- Preload the counter near all-ones via force (COUNT_W=4: 15 retires, then 2 more) → instr_count_o stays 4'hF.
- With CPU_SEQ_STALL_TIMEOUT_EN and STALL_TIMEOUT=8: waitrequest_i=1 with read for 8 cycles → HALT, fault_o=1, halt_o pulse, count unchanged. 7 stall cycles then release → no fault.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multicycle FETCH/EXEC1/EXEC2 sequencer with memory-stall hold, halt detection and retire count.
// Optional stall-timeout fault is enabled by defining CPU_SEQ_STALL_TIMEOUT_EN.
module cpu_sequencer #(
  parameter int unsigned COUNT_W       = 32,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               waitrequest_i,
  input  logic               ram_read_en_i,
  input  logic               ram_write_en_i,
  input  logic [31:0]        pc_next_i,
  output logic [1:0]         state_o,
  output logic               stall_o,
  output logic               active_o,
  output logic               halt_o,
  output logic               fault_o,
  output logic [COUNT_W-1:0] instr_count_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               active_q, active_d;
  logic               halt_q, halt_d;
  logic               fault_q, fault_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               mem_busy;
  logic               timeout;

  assign mem_busy = (ram_read_en_i | ram_write_en_i) & waitrequest_i;
  assign stall_o  = mem_busy & (state_q != HALT);

`ifdef CPU_SEQ_STALL_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(STALL_TIMEOUT + 1);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  // Timeout fires during the STALL_TIMEOUT-th consecutive stalled cycle.
  assign timeout     = stall_o & (stall_cnt_q == STALL_W'(STALL_TIMEOUT - 1));
  assign stall_cnt_d = stall_o ? stall_cnt_q + STALL_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end
`else
  logic unused_timeout_c;

  assign timeout          = 1'b0;
  assign unused_timeout_c = ^32'(STALL_TIMEOUT);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      active_q <= 1'b1;
      halt_q   <= 1'b0;
      fault_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      halt_q   <= halt_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    halt_d  = 1'b0;
    fault_d = fault_q;
    count_d = count_q;

    unique case (state_q)
      FETCH: if (!mem_busy) state_d = EXEC1;
      EXEC1: if (!mem_busy) state_d = EXEC2;
      EXEC2: begin
        if (!mem_busy) begin
          if (count_q != '1) count_d = count_q + COUNT_W'(1);
          if (pc_next_i == 32'h0) begin
            state_d = HALT;
            halt_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

    // A timeout can only occur while stalled, so no retire was taken above.
    if (timeout) begin
      state_d = HALT;
      halt_d  = 1'b1;
      fault_d = 1'b1;
    end

    active_d = (state_d != HALT);
  end

  assign state_o       = state_q;
  assign active_o      = active_q;
  assign halt_o        = halt_q;
  assign fault_o       = fault_q;
  assign instr_count_o = count_q;

endmodule
